clk_div_bank: RTL and testbench

Multi-channel programmable clock/tick generator, successor to the fixed single-channel divide-by-period block. Generates NUM_CH independent divided square waves plus a one-cycle tick per period from the single system clock. Each divisor is runtime-programmable, with glitch-free updates at period boundaries. Feeds timer, display-scan and debounce logic in the answering-machine datapath.

---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div_ch.sv | 104 ++++++++++
 rtl/clk_div_bank.sv | 68 ++++++
 tb/tb_clk_div_bank.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clk_div_bank tick/clock generator.
package clk_div_pkg;

   localparam int unsigned MIN_DIV       = 2;
   localparam int unsigned DEFAULT_DIV_W = 32;

   // Width of a channel index; never narrower than one bit.
   function automatic int unsigned ch_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : clk_div_pkg

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, active/shadow divisor, registered
// square wave and period-start tick.
//   clk, rst     : system clock, synchronous active-high reset
//   en           : run enable (level)
//   wr, wr_div   : validated divisor write for this channel
//   clk_out      : square wave, high for ceil(div/2) cycles of each period
//   tick         : one-cycle pulse in the first cycle of each period
//   pend         : a shadow divisor is waiting for the next period boundary
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int unsigned DIV_W       = DEFAULT_DIV_W,
   parameter int unsigned DEFAULT_DIV = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_div,
   output logic             clk_out,
   output logic             tick,
   output logic             pend
);

   logic [DIV_W-1:0] cnt_q,      cnt_d;
   logic [DIV_W-1:0] act_div_q,  act_div_d;
   logic [DIV_W-1:0] pend_div_q, pend_div_d;
   logic             pend_vld_q, pend_vld_d;
   logic             run_q,      run_d;
   logic             clk_out_q,  clk_out_d;
   logic             tick_q,     tick_d;

   logic             last_c;
   logic [DIV_W-1:0] hi_len_c;

   // Next-state: period counting, divisor shadowing and output decode.
   always_comb begin
      cnt_d      = cnt_q;
      act_div_d  = act_div_q;
      pend_div_d = pend_div_q;
      pend_vld_d = pend_vld_q;
      run_d      = run_q;
      clk_out_d  = 1'b0;
      tick_d     = 1'b0;

      last_c   = (cnt_q == act_div_q - DIV_W'(1));
      // ceil(div/2) without overflowing at the all-ones divisor
      hi_len_c = act_div_q - (act_div_q >> 1);

      if (!en) begin
         // Stopped: phase cleared, any shadow value takes effect at once;
         // a direct write wins over an older shadow value.
         cnt_d      = '0;
         run_d      = 1'b0;
         pend_vld_d = 1'b0;
         if (pend_vld_q) act_div_d = pend_div_q;
         if (wr)         act_div_d = wr_div;
      end else begin
         run_d = 1'b1;
         if (!run_q || last_c) begin
            // Period start (first enabled cycle or wrap)
            cnt_d      = '0;
            clk_out_d  = 1'b1;
            tick_d     = 1'b1;
            pend_vld_d = 1'b0;
            if (wr)              act_div_d = wr_div;
            else if (pend_vld_q) act_div_d = pend_div_q;
         end else begin
            cnt_d     = cnt_q + DIV_W'(1);
            clk_out_d = (cnt_d < hi_len_c);
            if (wr) begin
               pend_div_d = wr_div;
               pend_vld_d = 1'b1;
            end
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         act_div_q  <= DIV_W'(DEFAULT_DIV);
         pend_div_q <= '0;
         pend_vld_q <= 1'b0;
         run_q      <= 1'b0;
         clk_out_q  <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         act_div_q  <= act_div_d;
         pend_div_q <= pend_div_d;
         pend_vld_q <= pend_vld_d;
         run_q      <= run_d;
         clk_out_q  <= clk_out_d;
         tick_q     <= tick_d;
      end
   end

   assign clk_out = clk_out_q;
   assign tick    = tick_q;
   assign pend    = pend_vld_q;

endmodule : clk_div_ch

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent programmable clock/tick dividers.
//   clk, rst  : system clock, synchronous active-high reset
//   en        : per-channel run enable
//   cfg_wr    : divisor write strobe; cfg_ch selects channel, cfg_div value
//   cfg_err   : registered pulse when a write is rejected
//   cfg_pend  : per-channel shadow divisor waiting for a period boundary
//   clk_out   : per-channel divided square wave
//   tick      : per-channel one-cycle pulse at period start
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned DIV_W       = DEFAULT_DIV_W,
   parameter int unsigned DEFAULT_DIV = 100
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH-1:0]             en,
   input  logic                          cfg_wr,
   input  logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]              cfg_div,
   output logic                          cfg_err,
   output logic [NUM_CH-1:0]             cfg_pend,
   output logic [NUM_CH-1:0]             clk_out,
   output logic [NUM_CH-1:0]             tick
);

   localparam int unsigned CH_W = ch_idx_w(NUM_CH);

   logic              cfg_ok_c;
   logic [NUM_CH-1:0] ch_wr_c;
   logic              cfg_err_q, cfg_err_d;

   // Write validation and channel decode; compare widened so an
   // out-of-range index is visible whatever NUM_CH is.
   always_comb begin
      cfg_ok_c  = (32'(cfg_ch) < 32'(NUM_CH)) && (cfg_div >= DIV_W'(MIN_DIV));
      cfg_err_d = cfg_wr && !cfg_ok_c;
      ch_wr_c   = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         ch_wr_c[i] = cfg_wr && cfg_ok_c && (cfg_ch == CH_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cfg_err_q <= 1'b0;
      else     cfg_err_q <= cfg_err_d;
   end

   assign cfg_err = cfg_err_q;

   for (genvar gi = 0; gi < int'(NUM_CH); gi++) begin : g_ch
      clk_div_ch #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .en      (en[gi]),
         .wr      (ch_wr_c[gi]),
         .wr_div  (cfg_div),
         .clk_out (clk_out[gi]),
         .tick    (tick[gi]),
         .pend    (cfg_pend[gi])
      );
   end

endmodule : clk_div_bank

// File: tb/tb_clk_div_bank.sv
// Directed self-checking bench for clk_div_bank (five channels so that
// cfg_ch == NUM_CH is representable on the 3-bit index).
module tb_clk_div_bank;

   localparam int NUM_CH = 5;
   localparam int DIV_W  = 32;

   logic              clk;
   logic              rst;
   logic [NUM_CH-1:0] en;
   logic              cfg_wr;
   logic [2:0]        cfg_ch;
   logic [DIV_W-1:0]  cfg_div;
   logic              cfg_err;
   logic [NUM_CH-1:0] cfg_pend;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;

   int vec_cnt = 0;
   int err_cnt = 0;

   clk_div_bank #(
      .NUM_CH      (NUM_CH),
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (100)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .cfg_wr   (cfg_wr),
      .cfg_ch   (cfg_ch),
      .cfg_div  (cfg_div),
      .cfg_err  (cfg_err),
      .cfg_pend (cfg_pend),
      .clk_out  (clk_out),
      .tick     (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Check n consecutive cycles of channel ch against a divisor-div period,
   // the first observed cycle being at phase pos0.
   task automatic watch(input int ch, input int n, input int div, input int pos0,
                        input logic pend_exp);
      int pos = pos0;
      logic [2:0] ci = 3'(ch);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk($sformatf("ch%0d div%0d pos%0d clk_out", ch, div, pos),
             32'(clk_out[ci]), 32'(pos < div - div / 2));
         chk($sformatf("ch%0d div%0d pos%0d tick", ch, div, pos),
             32'(tick[ci]), 32'(pos == 0));
         chk($sformatf("ch%0d div%0d pos%0d cfg_pend", ch, div, pos),
             32'(cfg_pend[ci]), 32'(pend_exp));
         pos = (pos + 1) % div;
      end
   endtask

   initial begin
      rst     = 1'b1;
      en      = '0;
      cfg_wr  = 1'b0;
      cfg_ch  = '0;
      cfg_div = '0;
      repeat (2) @(negedge clk);
      chk("reset clk_out",  32'(clk_out),  32'h0);
      chk("reset tick",     32'(tick),     32'h0);
      chk("reset cfg_err",  32'(cfg_err),  32'h0);
      chk("reset cfg_pend", 32'(cfg_pend), 32'h0);
      rst = 1'b0;

      // Default divisor 100 on ch0: 50 high / 50 low, tick at en+1
      en[0] = 1'b1;
      watch(0, 200, 100, 0, 1'b0);

      // Mid-period write of 5 to running ch1, applied at the boundary
      en[1] = 1'b1;
      watch(1, 11, 100, 0, 1'b0);
      cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_div = 32'd5;
      watch(1, 1, 100, 11, 1'b1);
      cfg_wr = 1'b0;
      chk("good write cfg_err", 32'(cfg_err), 32'h0);
      watch(1, 88, 100, 12, 1'b1);
      watch(1, 10, 5, 0, 1'b0);

      // Rejected writes: divisor below 2, channel out of range
      cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_div = 32'd1;
      watch(1, 1, 5, 0, 1'b0);
      chk("div1 cfg_err", 32'(cfg_err), 32'h1);
      cfg_ch = 3'(NUM_CH); cfg_div = 32'd3;
      watch(1, 1, 5, 1, 1'b0);
      chk("bad ch cfg_err", 32'(cfg_err), 32'h1);
      cfg_wr = 1'b0;
      watch(1, 1, 5, 2, 1'b0);
      chk("err clears", 32'(cfg_err), 32'h0);
      chk("rejected no pend", 32'(cfg_pend), 32'h0);
      watch(1, 5, 5, 3, 1'b0);

      // Write to disabled ch2 takes effect directly, no pend
      cfg_wr = 1'b1; cfg_ch = 3'd2; cfg_div = 32'd10;
      @(negedge clk);
      chk("idle write cfg_pend", 32'(cfg_pend), 32'h0);
      chk("idle ch2 clk_out", 32'(clk_out[2]), 32'h0);
      cfg_wr = 1'b0; en[2] = 1'b1;
      watch(2, 4, 10, 0, 1'b0);
      // 7 then 9 in one period: last write wins
      cfg_wr = 1'b1; cfg_div = 32'd7;
      watch(2, 1, 10, 4, 1'b1);
      cfg_div = 32'd9;
      watch(2, 1, 10, 5, 1'b1);
      cfg_wr = 1'b0;
      watch(2, 4, 10, 6, 1'b1);
      watch(2, 9, 9, 0, 1'b0);
      // Write sampled on the wrap cycle applies to the very next period
      cfg_wr = 1'b1; cfg_div = 32'd4;
      watch(2, 1, 4, 0, 1'b0);
      cfg_wr = 1'b0;
      watch(2, 8, 4, 1, 1'b0);

      // ch3: pending value applied by disable, phase restarts on re-enable
      en[3] = 1'b1;
      watch(3, 5, 100, 0, 1'b0);
      cfg_wr = 1'b1; cfg_ch = 3'd3; cfg_div = 32'd6;
      watch(3, 1, 100, 5, 1'b1);
      cfg_wr = 1'b0; en[3] = 1'b0;
      @(negedge clk);
      chk("ch3 disable clk_out", 32'(clk_out[3]),  32'h0);
      chk("ch3 disable tick",    32'(tick[3]),     32'h0);
      chk("ch3 disable pend",    32'(cfg_pend[3]), 32'h0);
      en[3] = 1'b1;
      watch(3, 12, 6, 0, 1'b0);

      // Reset mid-operation beats a same-cycle write and held enables
      rst = 1'b1; cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_div = 32'd3;
      @(negedge clk);
      chk("mid rst clk_out",  32'(clk_out),  32'h0);
      chk("mid rst tick",     32'(tick),     32'h0);
      chk("mid rst cfg_pend", 32'(cfg_pend), 32'h0);
      chk("mid rst cfg_err",  32'(cfg_err),  32'h0);
      rst = 1'b0; cfg_wr = 1'b0;
      for (int i = 0; i < 101; i++) begin
         @(negedge clk);
         chk($sformatf("post rst clk_out pos%0d", i % 100), 32'(clk_out),
             ((i % 100) < 50) ? 32'h0f : 32'h0);
         chk($sformatf("post rst tick pos%0d", i % 100), 32'(tick),
             ((i % 100) == 0) ? 32'h0f : 32'h0);
         chk($sformatf("post rst cfg_pend pos%0d", i % 100), 32'(cfg_pend), 32'h0);
      end
      chk("post rst cfg_err", 32'(cfg_err), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule : tb_clk_div_bank
